// File: rtl/reduction_pkg.sv
// Shared constants, FSM state type and saturation limits for the reduction tree.
// The REDUCTION_SAT_EN macro enables saturating arithmetic in the users of this package.
package reduction_pkg;

  localparam int LANES_DEF     = 8;
  localparam int dwidth_double = 64;

  localparam logic [dwidth_double-1:0] SAT_MAX_D =
    {1'b0, {(dwidth_double-1){1'b1}}};
  localparam logic [dwidth_double-1:0] SAT_MIN_D =
    {1'b1, {(dwidth_double-1){1'b0}}};

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } red_state_e;

  // Limits for a w-bit signed lane, w <= dwidth_double
  function automatic logic [dwidth_double-1:0] sat_lim(
    input logic neg,
    input int   w
  );
    return neg ? (SAT_MIN_D >> (dwidth_double - w))
               : (SAT_MAX_D >> (dwidth_double - w));
  endfunction

endpackage

// File: rtl/reduce_add_stage.sv
// One registered level of the adder tree: PAIRS pairwise sums plus valid/last pipe.
// Defining REDUCTION_SAT_EN turns the adders into signed saturating adders.
module reduce_add_stage
  import reduction_pkg::*;
#(
  parameter int PAIRS  = 4,
  parameter int DWIDTH = dwidth_double
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [2*PAIRS*DWIDTH-1:0] in_data,
  input  logic                      in_valid,
  input  logic                      in_last,
  output logic [PAIRS*DWIDTH-1:0]   out_data,
  output logic                      out_valid,
  output logic                      out_last
);

`ifdef REDUCTION_SAT_EN
  localparam logic [DWIDTH-1:0] SAT_MAX =
    DWIDTH'(sat_lim(1'b0, DWIDTH));
  localparam logic [DWIDTH-1:0] SAT_MIN =
    DWIDTH'(sat_lim(1'b1, DWIDTH));
`endif

  function automatic logic [DWIDTH-1:0] add2(
    input logic [DWIDTH-1:0] a,
    input logic [DWIDTH-1:0] b
  );
    logic [DWIDTH-1:0] s;
    s = a + b;
`ifdef REDUCTION_SAT_EN
    if (a[DWIDTH-1] == b[DWIDTH-1] &&
        s[DWIDTH-1] != a[DWIDTH-1])
      s = a[DWIDTH-1] ? SAT_MIN : SAT_MAX;
`endif
    return s;
  endfunction

  logic [PAIRS*DWIDTH-1:0] data_d, data_q;
  logic                    valid_d, valid_q;
  logic                    last_d, last_q;

  // Sums only load on valid beats so bubbles leave the level untouched
  always_comb begin
    data_d  = data_q;
    valid_d = in_valid;
    last_d  = in_valid & in_last;
    if (in_valid) begin
      for (int p = 0; p < PAIRS; p++) begin
        data_d[p*DWIDTH +: DWIDTH] =
          add2(in_data[2*p*DWIDTH +: DWIDTH],
               in_data[(2*p+1)*DWIDTH +: DWIDTH]);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign out_last  = last_q;

endmodule

// File: rtl/reduction_tree_acc_int.sv
// Multi-lane integer reduction: log2(LANES) adder levels feeding a beat accumulator.
// Defining REDUCTION_SAT_EN makes every adder signed-saturating.
module reduction_tree_acc_int
  import reduction_pkg::*;
#(
  parameter int LANES  = LANES_DEF,
  parameter int DWIDTH = dwidth_double,
  parameter int CWIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [LANES*DWIDTH-1:0] inp1,
  input  logic                    in_valid,
  input  logic                    in_last,
  output logic [DWIDTH-1:0]       out1,
  output logic                    out_valid,
  output logic [CWIDTH-1:0]       out_count,
  output logic                    busy
);

  localparam int S  = $clog2(LANES);
  localparam int NL = 2*LANES - 1;

`ifdef REDUCTION_SAT_EN
  localparam logic [DWIDTH-1:0] SAT_MAX =
    DWIDTH'(sat_lim(1'b0, DWIDTH));
  localparam logic [DWIDTH-1:0] SAT_MIN =
    DWIDTH'(sat_lim(1'b1, DWIDTH));
`endif

  function automatic logic [DWIDTH-1:0] add2(
    input logic [DWIDTH-1:0] a,
    input logic [DWIDTH-1:0] b
  );
    logic [DWIDTH-1:0] s;
    s = a + b;
`ifdef REDUCTION_SAT_EN
    if (a[DWIDTH-1] == b[DWIDTH-1] &&
        s[DWIDTH-1] != a[DWIDTH-1])
      s = a[DWIDTH-1] ? SAT_MIN : SAT_MAX;
`endif
    return s;
  endfunction

  // All tree levels packed back to back: level k starts at lane 2L-2(L>>k)
  logic [NL*DWIDTH-1:0] tree;
  logic [S:0]           lv;
  logic [S:0]           ll;

  assign tree[LANES*DWIDTH-1:0] = inp1;
  assign lv[0] = in_valid;
  assign ll[0] = in_valid & in_last;

  for (genvar k = 0; k < S; k++) begin : g_stage
    localparam int PAIRS = LANES >> (k+1);
    localparam int OI = (2*LANES - 2*(LANES >> k))*DWIDTH;
    localparam int OO = (2*LANES - 2*PAIRS)*DWIDTH;
    reduce_add_stage #(
      .PAIRS (PAIRS),
      .DWIDTH(DWIDTH)
    ) u_stage (
      .clk      (clk),
      .rst      (rst),
      .in_data  (tree[OI +: 2*PAIRS*DWIDTH]),
      .in_valid (lv[k]),
      .in_last  (ll[k]),
      .out_data (tree[OO +: PAIRS*DWIDTH]),
      .out_valid(lv[k+1]),
      .out_last (ll[k+1])
    );
  end

  logic [DWIDTH-1:0] t_data;
  logic              t_valid;
  logic              t_last;

  assign t_data  = tree[NL*DWIDTH-1 -: DWIDTH];
  assign t_valid = lv[S];
  assign t_last  = ll[S];

  red_state_e        state_q, state_d;
  logic [DWIDTH-1:0] acc_q, acc_d;
  logic [DWIDTH-1:0] out1_q, out1_d;
  logic [DWIDTH-1:0] sum;
  logic [CWIDTH-1:0] cnt_q, cnt_d, cnt_nx;
  logic [CWIDTH-1:0] oc_q, oc_d;
  logic              ov_q, ov_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      out1_q  <= '0;
      oc_q    <= '0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      out1_q  <= out1_d;
      oc_q    <= oc_d;
      ov_q    <= ov_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (t_valid)
      state_d = t_last ? IDLE : ACCUM;
  end

  // IDLE means no partial sum, so the first beat starts from zero
  always_comb begin
    sum    = add2((state_q == IDLE) ? '0 : acc_q, t_data);
    cnt_nx = (state_q == IDLE) ? CWIDTH'(1)
           : (&cnt_q) ? cnt_q : cnt_q + 1'b1;
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    out1_d = out1_q;
    oc_d   = oc_q;
    ov_d   = 1'b0;
    if (t_valid) begin
      if (t_last) begin
        out1_d = sum;
        oc_d   = cnt_nx;
        ov_d   = 1'b1;
        acc_d  = '0;
        cnt_d  = '0;
      end else begin
        acc_d  = sum;
        cnt_d  = cnt_nx;
      end
    end
  end

  assign out1      = out1_q;
  assign out_count = oc_q;
  assign out_valid = ov_q;
  assign busy      = (state_q == ACCUM) | (|lv[S:1]);

endmodule

// File: tb/tb_reduction_tree_acc_int.sv
// Directed bench for reduction_tree_acc_int at LANES=8, DWIDTH=64.
// Expectations follow REDUCTION_SAT_EN when the bench is built with it.
module tb_reduction_tree_acc_int;

  localparam int LANES  = 8;
  localparam int DWIDTH = 64;
  localparam int CWIDTH = 16;

  logic                    clk = 1'b0;
  logic                    rst = 1'b0;
  logic [LANES*DWIDTH-1:0] inp1 = '0;
  logic                    in_valid = 1'b0;
  logic                    in_last = 1'b0;
  logic [DWIDTH-1:0]       out1;
  logic                    out_valid;
  logic [CWIDTH-1:0]       out_count;
  logic                    busy;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int t0;

  logic [63:0] q_sum[$];
  int          q_cnt[$];
  int          q_cyc[$];

  reduction_tree_acc_int #(
    .LANES (LANES),
    .DWIDTH(DWIDTH),
    .CWIDTH(CWIDTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .inp1     (inp1),
    .in_valid (in_valid),
    .in_last  (in_last),
    .out1     (out1),
    .out_valid(out_valid),
    .out_count(out_count),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (out_valid) begin
      q_sum.push_back(out1);
      q_cnt.push_back(int'(out_count));
      q_cyc.push_back(cyc);
    end
  end

  task automatic check(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [LANES*DWIDTH-1:0] all_lanes(
    input logic [63:0] v
  );
    logic [LANES*DWIDTH-1:0] r;
    for (int i = 0; i < LANES; i++)
      r[i*DWIDTH +: DWIDTH] = v;
    return r;
  endfunction

  task automatic drive(
    input logic [LANES*DWIDTH-1:0] d,
    input logic                    v,
    input logic                    l
  );
    inp1     = d;
    in_valid = v;
    in_last  = l;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    q_sum.delete();
    q_cnt.delete();
    q_cyc.delete();
  endtask

  initial begin
    logic [LANES*DWIDTH-1:0] d;
    logic [63:0]             exp_ovf;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out1", out1, 64'd0);
    check("rst_out_count", 64'(out_count), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // single beat, lanes 1..8
    clear_q();
    for (int i = 0; i < LANES; i++)
      d[i*DWIDTH +: DWIDTH] = 64'(i + 1);
    t0 = cyc;
    drive(d, 1'b1, 1'b1);
    check("t1_busy_inflight", 64'(busy), 64'd1);
    idle(6);
    check("t1_pulses", 64'(q_sum.size()), 64'd1);
    if (q_sum.size() > 0) begin
      check("t1_sum", q_sum[0], 64'd36);
      check("t1_count", 64'(q_cnt[0]), 64'd1);
      check("t1_latency", 64'(q_cyc[0] - t0), 64'd4);
    end
    check("t1_busy_idle", 64'(busy), 64'd0);
    idle(3);
    check("t1_hold_out1", out1, 64'd36);
    check("t1_hold_count", 64'(out_count), 64'd1);

    // three beats with a bubble carrying a stray last
    clear_q();
    drive(all_lanes(64'd1), 1'b1, 1'b0);
    drive(all_lanes(64'd1), 1'b1, 1'b0);
    drive(all_lanes(64'd5), 1'b0, 1'b1);
    drive(all_lanes(64'd1), 1'b1, 1'b1);
    idle(6);
    check("t2_pulses", 64'(q_sum.size()), 64'd1);
    if (q_sum.size() > 0) begin
      check("t2_sum", q_sum[0], 64'd24);
      check("t2_count", 64'(q_cnt[0]), 64'd3);
    end

    // back-to-back single-beat reductions
    clear_q();
    for (int k = 1; k <= 5; k++)
      drive(all_lanes(64'(k)), 1'b1, 1'b1);
    idle(6);
    check("t3_pulses", 64'(q_sum.size()), 64'd5);
    for (int i = 0; i < q_sum.size() && i < 5; i++) begin
      check($sformatf("t3_sum%0d", i), q_sum[i], 64'(8*(i+1)));
      check($sformatf("t3_cnt%0d", i), 64'(q_cnt[i]), 64'd1);
      check($sformatf("t3_gap%0d", i),
            64'(q_cyc[i] - q_cyc[0]), 64'(i));
    end

    // overflow of the signed maximum in every lane
`ifdef REDUCTION_SAT_EN
    exp_ovf = 64'h7FFF_FFFF_FFFF_FFFF;
`else
    exp_ovf = 64'hFFFF_FFFF_FFFF_FFF8;
`endif
    clear_q();
    drive(all_lanes(64'h7FFF_FFFF_FFFF_FFFF), 1'b1, 1'b1);
    idle(6);
    check("t4_pulses", 64'(q_sum.size()), 64'd1);
    if (q_sum.size() > 0)
      check("t4_sum", q_sum[0], exp_ovf);

    // reset in the middle of an open reduction
    clear_q();
    drive(all_lanes(64'd3), 1'b1, 1'b0);
    drive(all_lanes(64'd3), 1'b1, 1'b0);
    rst = 1'b0;
    #1;
    check("t5_async_out1", out1, 64'd0);
    check("t5_async_count", 64'(out_count), 64'd0);
    check("t5_async_busy", 64'(busy), 64'd0);
    idle(2);
    rst = 1'b1;
    drive(all_lanes(64'd2), 1'b1, 1'b1);
    idle(8);
    check("t5_pulses", 64'(q_sum.size()), 64'd1);
    if (q_sum.size() > 0) begin
      check("t5_sum", q_sum[0], 64'd16);
      check("t5_count", 64'(q_cnt[0]), 64'd1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/reduction_tree_acc_int.md
REDUCTION_TREE_ACC_INT -- requirements
Module: reduction_tree_acc_int

Interface
REQ-001 SHALL have parameter LANES, default 8, number of DWIDTH-bit lanes per input beat; power of two, 2..64.
REQ-002 SHALL have parameter DWIDTH, default dwidth_double, integer width of each lane, sum and accumulator.
REQ-003 SHALL have parameter CWIDTH, default 16, width of the beat counter.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port inp1  input  LANES*DWIDTH  beat data; lane i at bits [(i+1)*DWIDTH-1 : i*DWIDTH].
REQ-007 SHALL have port in_valid  input  1  beat on inp1 is sampled this cycle.
REQ-008 SHALL have port in_last  input  1  qualified by in_valid; beat closes the current reduction.
REQ-009 SHALL have port out1  output  DWIDTH  reduced sum of all lanes of all beats of one reduction.
REQ-010 SHALL have port out_valid  output  1  one-cycle pulse; out1 and out_count valid.
REQ-011 SHALL have port out_count  output  CWIDTH  number of beats in the reported reduction.
REQ-012 SHALL have port busy  output  1  high while a reduction is open or beats are in the tree.

Function
REQ-013 SHALL reduce each valid beat through a binary adder tree of S=log2(LANES) registered stages, adding lanes pairwise in index order.
REQ-014 SHALL carry a valid bit and a last bit alongside each tree stage; bubbles (in_valid low) SHALL NOT alter the accumulator.
REQ-015 SHALL implement FSM states IDLE and ACCUM: IDLE->ACCUM on first tree-output beat with last=0; ACCUM->IDLE on tree-output beat with last=1; IDLE->IDLE on beat with last=1 (single-beat reduction).
REQ-016 SHALL, on a tree-output beat, form sum = (state==IDLE ? 0 : acc) + tree_out, and either store it in acc (last=0) or register it onto out1 with out_valid=1 (last=1) and clear acc.
REQ-017 SHALL yield latency L=S+1 cycles from sampling in_valid&in_last to out_valid high.
REQ-018 SHALL accept one beat per cycle indefinitely, back-to-back reductions included, with no stall cycles.
REQ-019 SHALL wrap all additions modulo 2^DWIDTH (two's complement) unless REQ-026 applies.
REQ-020 SHALL count beats per reduction in out_count, saturating at 2^CWIDTH-1.
REQ-021 SHALL hold out1 and out_count stable between out_valid pulses.
REQ-022 SHALL ignore in_last when in_valid is low.

Reset
REQ-023 SHALL, on rst low, asynchronously clear out1, out_count, out_valid, busy, acc, beat counter, all stage valid/last bits and return FSM to IDLE.
REQ-024 SHALL discard any partial reduction and in-flight beats when reset asserts mid-operation; no out_valid SHALL follow for them.
REQ-025 SHALL sample the first beat on the first rising clk edge after rst deasserts.

Configuration
REQ-026 SHALL, with macro REDUCTION_SAT_EN defined, use signed saturating addition at every tree stage and the accumulator (clamp to 2^(DWIDTH-1)-1 / -2^(DWIDTH-1)); without it, wrap per REQ-019; latency identical in both builds.

Structure
REQ-027 SHALL take LANES/DWIDTH defaults, reduction FSM state enum and saturation-limit constants from a shared package reduction_pkg.
REQ-028 SHALL implement one tree stage as sub-module reduce_add_stage (parametrised pair count, registered sums, valid/last pipe), instantiated S times via generate.

Verification (LANES=8, DWIDTH=64, L=4)
REQ-029 SHALL check: one beat lanes 1..8, in_last=1 -> 4 cycles later out_valid=1, out1=36, out_count=1.
REQ-030 SHALL check: 3 beats all lanes=1, bubble after beat 2, last on beat 3 -> out1=24, out_count=3, single pulse.
REQ-031 SHALL check: back-to-back single-beat reductions every cycle, lanes=k at cycle k -> out1=8k each consecutive cycle.
REQ-032 SHALL check: all lanes=0x7FFF_FFFF_FFFF_FFFF -> out1=0xFFFF_FFFF_FFFF_FFF8 wrapped; with REDUCTION_SAT_EN out1=0x7FFF_FFFF_FFFF_FFFF.
REQ-033 SHALL check: rst low after 2 beats of an open reduction, then a new single beat lanes=2 -> only out1=16, out_count=1 reported.
